// File: rtl/conv2_pkg.sv
// Shared types and constants for the conv2 valid-correlation engine.
// Default kernel is a 3x3 Laplacian; accWidth() sizes the overflow-free accumulator.
package conv2_pkg;

  localparam int DEFAULT_SIZE      = 640;
  localparam int DEFAULT_SIZEKER   = 3;
  localparam int DEFAULT_WIDTH_BIT = 16;

  localparam logic signed [2:0][2:0][15:0] DEFAULT_KERNEL = {
    16'h0000, 16'hFFFF, 16'h0000,
    16'hFFFF, 16'h0004, 16'hFFFF,
    16'h0000, 16'hFFFF, 16'h0000
  };

  typedef enum logic {
    BUSY = 1'b0,
    DONE = 1'b1
  } state_t;

  // Full-precision products plus enough headroom to sum every kernel tap.
  function automatic int accWidth(input int widthBit, input int sizeKer);
    return 2 * widthBit + $clog2(sizeKer * sizeKer);
  endfunction

endpackage

// File: rtl/conv2_mac.sv
// Combinational window dot product for conv2, reduced to WIDTH_BIT bits.
// Wraps by default; define CONV2_SAT_EN to clamp to the signed WIDTH_BIT range instead.
module conv2_mac
  import conv2_pkg::*;
#(
  parameter int SIZEKer   = DEFAULT_SIZEKER,
  parameter int WIDTH_BIT = DEFAULT_WIDTH_BIT,
  parameter logic signed [SIZEKer-1:0][SIZEKer-1:0][WIDTH_BIT-1:0] KERNEL = DEFAULT_KERNEL
) (
  input  logic signed [SIZEKer-1:0][SIZEKer-1:0][WIDTH_BIT-1:0] i_window,
  output logic signed [WIDTH_BIT-1:0]                            o_result
);

  localparam int ACC_W = accWidth(WIDTH_BIT, SIZEKer);

  logic signed [2*WIDTH_BIT-1:0] w_prod;
  logic signed [ACC_W-1:0]       w_acc;

  always_comb begin
    w_prod = '0;
    w_acc  = '0;
    for (int i = 0; i < SIZEKer; i++) begin
      for (int j = 0; j < SIZEKer; j++) begin
        w_prod = $signed(i_window[i][j]) * $signed(KERNEL[i][j]);
        w_acc  = w_acc + ACC_W'(w_prod);
      end
    end
  end

`ifdef CONV2_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-WIDTH_BIT+1){1'b0}}, {(WIDTH_BIT-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-WIDTH_BIT+1){1'b1}}, {(WIDTH_BIT-1){1'b0}}};

  always_comb begin
    o_result = w_acc[WIDTH_BIT-1:0];
    if (w_acc > SAT_MAX) begin
      o_result = SAT_MAX[WIDTH_BIT-1:0];
    end else if (w_acc < SAT_MIN) begin
      o_result = SAT_MIN[WIDTH_BIT-1:0];
    end
  end
`else
  assign o_result = w_acc[WIDTH_BIT-1:0];
`endif

endmodule

// File: rtl/conv2.sv
// Sequential valid correlation of a SIZE x SIZE image with a SIZEKer x SIZEKer kernel,
// one output per clock in row-major order. Optional saturation via CONV2_SAT_EN (see conv2_mac).
module conv2
  import conv2_pkg::*;
#(
  parameter int SIZE      = DEFAULT_SIZE,
  parameter int SIZEKer   = DEFAULT_SIZEKER,
  parameter int WIDTH_BIT = DEFAULT_WIDTH_BIT,
  parameter logic signed [SIZEKer-1:0][SIZEKer-1:0][WIDTH_BIT-1:0] KERNEL = DEFAULT_KERNEL
) (
  input  logic                                                     clock,
  input  logic                                                     nreset,
  input  logic signed [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0]          inpMatrixI,
  output logic                                                     done,
  output logic signed [SIZE-SIZEKer:0][SIZE-SIZEKer:0][WIDTH_BIT-1:0] convIxKernelOut
);

  localparam int N     = SIZE - SIZEKer + 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  state_t r_state;
  state_t w_nextState;
  logic   w_advance;
  logic   w_last;

  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col;
  logic             r_done;
  logic signed [N-1:0][N-1:0][WIDTH_BIT-1:0]             r_out;
  logic signed [SIZEKer-1:0][SIZEKer-1:0][WIDTH_BIT-1:0] w_window;
  logic signed [WIDTH_BIT-1:0]                           w_result;

  always_comb begin
    w_window = '0;
    for (int i = 0; i < SIZEKer; i++) begin
      for (int j = 0; j < SIZEKer; j++) begin
        w_window[i][j] = inpMatrixI[IDX_W'(int'(r_row) + i)][IDX_W'(int'(r_col) + j)];
      end
    end
  end

  conv2_mac #(
    .SIZEKer   (SIZEKer),
    .WIDTH_BIT (WIDTH_BIT),
    .KERNEL    (KERNEL)
  ) u_mac (
    .i_window (w_window),
    .o_result (w_result)
  );

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state <= BUSY;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_advance   = 1'b0;
    w_last      = (r_row == CNT_W'(N - 1)) && (r_col == CNT_W'(N - 1));
    case (r_state)
      BUSY: begin
        w_advance = 1'b1;
        if (w_last) begin
          w_nextState = DONE;
        end
      end
      DONE:    w_nextState = DONE;
      default: w_nextState = BUSY;
    endcase
  end

  // Counters stop on the final element so they stay frozen once DONE is reached.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_row  <= '0;
      r_col  <= '0;
      r_done <= 1'b0;
      r_out  <= '0;
    end else if (w_advance) begin
      r_out[r_row][r_col] <= w_result;
      if (w_last) begin
        r_done <= 1'b1;
      end else if (r_col == CNT_W'(N - 1)) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign done            = r_done;
  assign convIxKernelOut = r_out;

endmodule

// File: tb/tb_conv2.sv
// Directed self-checking bench for conv2 at SIZE=5, SIZEKer=3, WIDTH_BIT=16 with the Laplacian kernel.
// Expected values are hand-computed; CONV2_SAT_EN selects the saturating expectation.
module tb_conv2;

  logic                         clock;
  logic                         nreset;
  logic [4:0][4:0][15:0]        img;
  logic                         done;
  logic signed [2:0][2:0][15:0] dutOut;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0][2:0][15:0] EXP_ZERO    = '0;
  localparam logic [2:0][2:0][15:0] EXP_IMPULSE = {
    16'h0000, 16'hFFFF, 16'h0000,
    16'hFFFF, 16'h0004, 16'hFFFF,
    16'h0000, 16'hFFFF, 16'h0000
  };
`ifdef CONV2_SAT_EN
  localparam logic [15:0] EXP_CENTER = 16'h7FFF;
`else
  localparam logic [15:0] EXP_CENTER = 16'hFFFC;
`endif
  localparam logic [2:0][2:0][15:0] EXP_BIG = {
    16'h0000, 16'h8001, 16'h0000,
    16'h8001, EXP_CENTER, 16'h8001,
    16'h0000, 16'h8001, 16'h0000
  };

  conv2 #(
    .SIZE      (5),
    .SIZEKer   (3),
    .WIDTH_BIT (16)
  ) dut (
    .clock           (clock),
    .nreset          (nreset),
    .inpMatrixI      (img),
    .done            (done),
    .convIxKernelOut (dutOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [143:0] observed,
                             input logic [143:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // mode 0: constant 7, 1: impulse at (2,2), 2: ramp 10r+c, 3: 32767 at (2,2), 4: random
  task automatic applyStimulus(input int mode);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        case (mode)
          0:       img[r][c] = 16'd7;
          1:       img[r][c] = (r == 2 && c == 2) ? 16'd1 : 16'd0;
          2:       img[r][c] = 16'(10 * r + c);
          3:       img[r][c] = (r == 2 && c == 2) ? 16'd32767 : 16'd0;
          default: img[r][c] = 16'($urandom);
        endcase
      end
    end
  endtask

  task automatic resetWith(input int mode, input string tag);
    @(negedge clock);
    nreset = 1'b0;
    applyStimulus(mode);
    #1;
    checkOutput({tag, "_rstDone"}, 144'(done), 144'(1'b0));
    checkOutput({tag, "_rstOut"}, dutOut, EXP_ZERO);
    @(negedge clock);
    nreset = 1'b1;
  endtask

  task automatic finishScan(input int edgesSoFar, input string tag,
                            input logic [143:0] expected);
    repeat (8 - edgesSoFar) @(posedge clock);
    #1;
    checkOutput({tag, "_doneEdge8"}, 144'(done), 144'(1'b0));
    @(posedge clock);
    #1;
    checkOutput({tag, "_doneEdge9"}, 144'(done), 144'(1'b1));
    checkOutput({tag, "_out"}, dutOut, expected);
  endtask

  initial begin
    nreset = 1'b0;
    applyStimulus(0);
    #1;
    checkOutput("init_done", 144'(done), 144'(1'b0));
    checkOutput("init_out", dutOut, EXP_ZERO);
    @(posedge clock);
    #1;
    checkOutput("heldReset_out", dutOut, EXP_ZERO);

    @(negedge clock);
    nreset = 1'b1;
    finishScan(0, "const7", EXP_ZERO);

    resetWith(1, "impulse");
    @(posedge clock);
    #1;
    checkOutput("impulse_e1_out01", 144'(dutOut[0][1]), 144'(16'h0000));
    @(posedge clock);
    #1;
    checkOutput("impulse_e2_out01", 144'(dutOut[0][1]), 144'(16'hFFFF));
    repeat (2) @(posedge clock);
    #1;
    checkOutput("impulse_e4_out11", 144'(dutOut[1][1]), 144'(16'h0000));
    @(posedge clock);
    #1;
    checkOutput("impulse_e5_out11", 144'(dutOut[1][1]), 144'(16'h0004));
    finishScan(5, "impulse", EXP_IMPULSE);

    resetWith(2, "ramp");
    finishScan(0, "ramp", EXP_ZERO);

    resetWith(3, "big");
    finishScan(0, "big", EXP_BIG);

    resetWith(1, "midRst");
    repeat (4) @(posedge clock);
    #1;
    checkOutput("midRst_e4_out01", 144'(dutOut[0][1]), 144'(16'hFFFF));
    nreset = 1'b0;
    #1;
    checkOutput("midRst_clrDone", 144'(done), 144'(1'b0));
    checkOutput("midRst_clrOut", dutOut, EXP_ZERO);
    @(negedge clock);
    nreset = 1'b1;
    finishScan(0, "rescan", EXP_IMPULSE);

    @(negedge clock);
    applyStimulus(4);
    repeat (20) @(posedge clock);
    #1;
    checkOutput("frozen_done", 144'(done), 144'(1'b1));
    checkOutput("frozen_out", dutOut, EXP_IMPULSE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
